// File: rtl/alu_issue_stage_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_issue_stage_if: issue, ALU-control and writeback bundle            |
// | Revision 1.0                                                            |
// +-----------------------------------------------------------------------+
interface alu_issue_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [XLEN-1:0] in_rs1;
    logic [XLEN-1:0] in_rs2;
    logic [XLEN-1:0] alu_A;
    logic [XLEN-1:0] alu_B;
    logic [2:0]      alu_ALUOp;
    logic [4:0]      alu_shamt;
    logic [6:0]      alu_funct7;
    logic [XLEN-1:0] alu_Result;
    logic            alu_Zero;
    logic            out_valid;
    logic            out_ready;
    logic [4:0]      out_rd;
    logic            out_we;
    logic [XLEN-1:0] out_result;
    logic            out_zero;
    logic            out_illegal;

    // master: decoder/ALU/writeback environment around the stage
    modport master (
        output in_valid, in_instr, in_rs1, in_rs2, alu_Result, alu_Zero, out_ready,
        input  in_ready, alu_A, alu_B, alu_ALUOp, alu_shamt, alu_funct7,
               out_valid, out_rd, out_we, out_result, out_zero, out_illegal
    );

    // slave: the issue stage itself
    modport slave (
        input  in_valid, in_instr, in_rs1, in_rs2, alu_Result, alu_Zero, out_ready,
        output in_ready, alu_A, alu_B, alu_ALUOp, alu_shamt, alu_funct7,
               out_valid, out_rd, out_we, out_result, out_zero, out_illegal
    );
endinterface
`default_nettype wire

// File: rtl/alu_issue_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | alu_issue_stage: two-entry RV32I OP/OP-IMM issue and retire pipeline   |
// | Revision 1.0                                                            |
// +-----------------------------------------------------------------------+
module alu_issue_stage #(
    parameter int          XLEN     = 32,
    parameter int unsigned RESET_PC = 0
) (
    input  wire logic         clk,
    input  wire logic         rst_n,
    alu_issue_stage_if.slave  bus
);
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] F7_ZERO   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;

    // No PC logic lives here; a non-zero reset PC has no effect.
    if (RESET_PC != 0) begin : g_reset_pc_ignored
    end

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [2:0]      aluop_map;
    logic            dec_legal;
    logic [XLEN-1:0] dec_a;
    logic [XLEN-1:0] dec_b;
    logic [2:0]      dec_aluop;
    logic [4:0]      dec_shamt;
    logic [6:0]      dec_funct7;

    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] alu_a_q, alu_b_q;
    logic [2:0]      alu_aluop_q;
    logic [4:0]      alu_shamt_q;
    logic [6:0]      alu_funct7_q;
    logic [4:0]      s1_rd_q;
    logic            s1_we_q, s1_illegal_q;

    logic            out_valid_q, out_valid_d;
    logic [4:0]      out_rd_q;
    logic            out_we_q, out_zero_q, out_illegal_q;
    logic [XLEN-1:0] out_result_q;

    logic            s2_free, s1_adv, in_ready, accept;

    assign opcode = bus.in_instr[6:0];
    assign funct3 = bus.in_instr[14:12];
    assign funct7 = bus.in_instr[31:25];

    always_comb begin
        aluop_map = 3'b000;
        case (funct3)
            3'b000:  aluop_map = 3'b000;
            3'b111:  aluop_map = 3'b001;
            3'b110:  aluop_map = 3'b010;
            3'b100:  aluop_map = 3'b011;
            3'b001:  aluop_map = 3'b100;
            3'b101:  aluop_map = 3'b101;
            3'b010:  aluop_map = 3'b110;
            default: aluop_map = 3'b111;
        endcase
    end

    always_comb begin
        dec_legal  = 1'b0;
        dec_a      = '0;
        dec_b      = '0;
        dec_aluop  = 3'b000;
        dec_shamt  = 5'd0;
        dec_funct7 = 7'd0;
        if (opcode == OPC_OP) begin
            dec_legal = (funct7 == F7_ZERO) ||
                        ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
        end else if (opcode == OPC_OPIMM) begin
            case (funct3)
                3'b001:  dec_legal = (funct7 == F7_ZERO);
                3'b101:  dec_legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
                default: dec_legal = 1'b1;
            endcase
        end
        // Illegal encodings leave every ALU control at zero.
        if (dec_legal) begin
            dec_a     = bus.in_rs1;
            dec_aluop = aluop_map;
            if (opcode == OPC_OP) begin
                dec_b      = bus.in_rs2;
                dec_shamt  = bus.in_rs2[4:0];
                dec_funct7 = funct7;
            end else begin
                dec_b     = {{(XLEN-12){bus.in_instr[31]}}, bus.in_instr[31:20]};
                dec_shamt = bus.in_instr[24:20];
                // Only shifts carry funct7; ADDI must never turn into a subtract.
                dec_funct7 = ((funct3 == 3'b001) || (funct3 == 3'b101)) ? funct7 : F7_ZERO;
            end
        end
    end

    assign s2_free  = !out_valid_q || bus.out_ready;
    assign s1_adv   = s1_valid_q && s2_free;
    assign in_ready = !s1_valid_q || s2_free;
    assign accept   = bus.in_valid && in_ready;

    assign s1_valid_d  = accept ? 1'b1 : (s1_adv ? 1'b0 : s1_valid_q);
    assign out_valid_d = s1_adv ? 1'b1 : (bus.out_ready ? 1'b0 : out_valid_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q   <= 1'b0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_aluop_q  <= 3'b000;
            alu_shamt_q  <= 5'd0;
            alu_funct7_q <= 7'd0;
            s1_rd_q      <= 5'd0;
            s1_we_q      <= 1'b0;
            s1_illegal_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (accept) begin
                alu_a_q      <= dec_a;
                alu_b_q      <= dec_b;
                alu_aluop_q  <= dec_aluop;
                alu_shamt_q  <= dec_shamt;
                alu_funct7_q <= dec_funct7;
                s1_rd_q      <= bus.in_instr[11:7];
                s1_we_q      <= dec_legal && (bus.in_instr[11:7] != 5'd0);
                s1_illegal_q <= !dec_legal;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q   <= 1'b0;
            out_rd_q      <= 5'd0;
            out_we_q      <= 1'b0;
            out_result_q  <= '0;
            out_zero_q    <= 1'b0;
            out_illegal_q <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            if (s1_adv) begin
                out_rd_q      <= s1_rd_q;
                out_we_q      <= s1_we_q;
                out_result_q  <= s1_illegal_q ? '0 : bus.alu_Result;
                out_zero_q    <= s1_illegal_q ? 1'b0 : bus.alu_Zero;
                out_illegal_q <= s1_illegal_q;
            end
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.alu_A       = alu_a_q;
    assign bus.alu_B       = alu_b_q;
    assign bus.alu_ALUOp   = alu_aluop_q;
    assign bus.alu_shamt   = alu_shamt_q;
    assign bus.alu_funct7  = alu_funct7_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_rd      = out_rd_q;
    assign bus.out_we      = out_we_q;
    assign bus.out_result  = out_result_q;
    assign bus.out_zero    = out_zero_q;
    assign bus.out_illegal = out_illegal_q;
endmodule
`default_nettype wire

// File: tb/tb_alu_issue_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_alu_issue_stage: directed bench with a behavioural RV32I ALU        |
// | Revision 1.0                                                            |
// +-----------------------------------------------------------------------+
module tb_alu_issue_stage;
    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    int          sent, got;
    logic        stalled, holding, acc;
    logic [31:0] held;
    logic [31:0] alu_res;

    always #5 clk = ~clk;

    alu_issue_stage_if #(.XLEN(32)) bus ();

    alu_issue_stage #(.XLEN(32), .RESET_PC(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Reference ALU sitting on the alu_* wires
    always_comb begin
        alu_res = 32'd0;
        case (bus.alu_ALUOp)
            3'b000:  alu_res = bus.alu_funct7[5] ? bus.alu_A - bus.alu_B : bus.alu_A + bus.alu_B;
            3'b001:  alu_res = bus.alu_A & bus.alu_B;
            3'b010:  alu_res = bus.alu_A | bus.alu_B;
            3'b011:  alu_res = bus.alu_A ^ bus.alu_B;
            3'b100:  alu_res = bus.alu_A << bus.alu_shamt;
            3'b101:  alu_res = bus.alu_funct7[5] ? 32'($signed(bus.alu_A) >>> bus.alu_shamt)
                                                 : bus.alu_A >> bus.alu_shamt;
            3'b110:  alu_res = {31'd0, $signed(bus.alu_A) < $signed(bus.alu_B)};
            default: alu_res = {31'd0, bus.alu_A < bus.alu_B};
        endcase
        bus.alu_Result = alu_res;
        bus.alu_Zero   = (alu_res == 32'd0);
    end

    function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [4:0] rd);
        return {f7, 5'd2, 5'd1, f3, rd, OPC_OP};
    endfunction

    function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [2:0] f3,
                                           input logic [4:0] rd, input logic [6:0] opc);
        return {imm, 5'd1, f3, rd, opc};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] instr, input logic [31:0] a, input logic [31:0] b);
        bus.in_valid = 1'b1;
        bus.in_instr = instr;
        bus.in_rs1   = a;
        bus.in_rs2   = b;
        #1;
        check1("send_in_ready", bus.in_ready, 1'b1);
        step();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.in_rs1    = 32'd0;
        bus.in_rs2    = 32'd0;
        bus.out_ready = 1'b1;
        step();
        step();
        rst_n = 1'b1;

        check1("rst_out_valid", bus.out_valid, 1'b0);
        check1("rst_in_ready", bus.in_ready, 1'b1);
        check("rst_alu_A", bus.alu_A, 32'd0);
        check("rst_alu_B", bus.alu_B, 32'd0);
        check("rst_alu_ALUOp", 32'(bus.alu_ALUOp), 32'd0);
        check("rst_out_result", bus.out_result, 32'd0);
        check("rst_out_rd", 32'(bus.out_rd), 32'd0);
        check1("rst_out_we", bus.out_we, 1'b0);

        // ADD x3 = 10 + 5
        send(r_type(7'h00, 3'b000, 5'd3), 32'd10, 32'd5);
        check("add_alu_A", bus.alu_A, 32'd10);
        check("add_alu_B", bus.alu_B, 32'd5);
        check("add_alu_ALUOp", 32'(bus.alu_ALUOp), 32'd0);
        check("add_alu_funct7", 32'(bus.alu_funct7), 32'd0);
        check1("add_latency", bus.out_valid, 1'b0);
        step();
        check1("add_out_valid", bus.out_valid, 1'b1);
        check("add_out_result", bus.out_result, 32'd15);
        check("add_out_rd", 32'(bus.out_rd), 32'd3);
        check1("add_out_we", bus.out_we, 1'b1);
        check1("add_out_illegal", bus.out_illegal, 1'b0);
        step();
        check1("drain_out_valid", bus.out_valid, 1'b0);

        // SUB 10-5, then 5-5
        send(r_type(7'h20, 3'b000, 5'd4), 32'd10, 32'd5);
        check("sub_alu_funct7", 32'(bus.alu_funct7), 32'h20);
        step();
        check("sub_out_result", bus.out_result, 32'd5);
        check1("sub_out_zero", bus.out_zero, 1'b0);
        send(r_type(7'h20, 3'b000, 5'd5), 32'd5, 32'd5);
        step();
        check("sub0_out_result", bus.out_result, 32'd0);
        check1("sub0_out_zero", bus.out_zero, 1'b1);

        // ADDI x6 = 10 + (-1); instr[30] set but must not subtract
        send(i_type(12'hFFF, 3'b000, 5'd6, OPC_OPIMM), 32'd10, 32'd0);
        check("addi_alu_funct7", 32'(bus.alu_funct7), 32'd0);
        check("addi_alu_B", bus.alu_B, 32'hFFFF_FFFF);
        step();
        check("addi_out_result", bus.out_result, 32'd9);
        check1("addi_out_we", bus.out_we, 1'b1);

        // SRAI x7 = 0x8000000F >>> 2
        send(i_type(12'h402, 3'b101, 5'd7, OPC_OPIMM), 32'h8000_000F, 32'd0);
        check("srai_alu_ALUOp", 32'(bus.alu_ALUOp), 32'd5);
        check("srai_alu_shamt", 32'(bus.alu_shamt), 32'd2);
        check("srai_alu_funct7", 32'(bus.alu_funct7), 32'h20);
        step();
        check("srai_out_result", bus.out_result, 32'hE000_0003);

        // XOR x8
        send(r_type(7'h00, 3'b100, 5'd8), 32'h0000_F0F0, 32'h0000_FF00);
        check("xor_alu_ALUOp", 32'(bus.alu_ALUOp), 32'd3);
        step();
        check("xor_out_result", bus.out_result, 32'h0000_0FF0);

        // ADD to x0: computed but not written
        send(r_type(7'h00, 3'b000, 5'd0), 32'd1, 32'd2);
        step();
        check("x0_out_result", bus.out_result, 32'd3);
        check1("x0_out_we", bus.out_we, 1'b0);

        // OP with funct7=0100000 on AND is illegal
        send(r_type(7'h20, 3'b111, 5'd9), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        check1("badop_out_illegal", bus.out_illegal, 1'b1);
        check1("badop_out_we", bus.out_we, 1'b0);
        check("badop_out_result", bus.out_result, 32'd0);

        // SLLI with funct7=0100000 is illegal
        send(i_type(12'h405, 3'b001, 5'd10, OPC_OPIMM), 32'd1, 32'd0);
        step();
        check1("badslli_out_illegal", bus.out_illegal, 1'b1);
        step();

        // Stream of four ADDs with writeback stalled for a while
        sent    = 0;
        got     = 0;
        stalled = 1'b0;
        holding = 1'b0;
        held    = 32'd0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            bus.out_ready = (cyc >= 5);
            if (sent < 4) begin
                bus.in_valid = 1'b1;
                bus.in_instr = r_type(7'h00, 3'b000, 5'(sent + 1));
                bus.in_rs1   = 32'(100 + sent);
                bus.in_rs2   = 32'(sent);
            end else begin
                bus.in_valid = 1'b0;
            end
            #1;
            if (holding && bus.out_valid)
                check("stream_hold_result", bus.out_result, held);
            if (bus.in_valid && !bus.in_ready)
                stalled = 1'b1;
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) begin
                check("stream_result", bus.out_result, 32'(100 + 2 * got));
                check("stream_rd", 32'(bus.out_rd), 32'(got + 1));
                got++;
                holding = 1'b0;
            end else if (bus.out_valid) begin
                holding = 1'b1;
                held    = bus.out_result;
            end
            step();
            if (acc) sent++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("stream_sent", 32'(sent), 32'd4);
        check("stream_got", 32'(got), 32'd4);
        check1("stream_stalled", stalled, 1'b1);
        check1("stream_empty", bus.out_valid, 1'b0);

        // LOAD opcode is not OP/OP-IMM
        send(i_type(12'hFFF, 3'b111, 5'd11, 7'b0000011), 32'd7, 32'd9);
        check("load_alu_ALUOp", 32'(bus.alu_ALUOp), 32'd0);
        check("load_alu_funct7", 32'(bus.alu_funct7), 32'd0);
        step();
        check1("load_out_illegal", bus.out_illegal, 1'b1);
        check1("load_out_we", bus.out_we, 1'b0);
        check("load_out_result", bus.out_result, 32'd0);
        check1("load_out_zero", bus.out_zero, 1'b0);
        step();

        // Reset with two entries in flight
        bus.out_ready = 1'b0;
        send(r_type(7'h00, 3'b000, 5'd1), 32'd1, 32'd1);
        send(r_type(7'h00, 3'b000, 5'd2), 32'd2, 32'd2);
        check1("inflight_out_valid", bus.out_valid, 1'b1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check1("midrst_out_valid", bus.out_valid, 1'b0);
        check1("midrst_in_ready", bus.in_ready, 1'b1);
        check("midrst_alu_A", bus.alu_A, 32'd0);
        check("midrst_out_result", bus.out_result, 32'd0);
        bus.out_ready = 1'b1;
        step();
        step();
        check1("midrst_no_ghost", bus.out_valid, 1'b0);
        send(r_type(7'h00, 3'b000, 5'd2), 32'd7, 32'd8);
        step();
        check("postrst_out_result", bus.out_result, 32'd15);
        check1("postrst_out_valid", bus.out_valid, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        errors++;
        $display("FAIL timeout: observed=running expected=finished");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
